light_ctrl_multi: RTL and testbench

Parametrised multi-channel successor to the single-button light FSM. Each channel has its own button, 2-flop synchroniser, debouncer and level FSM. Each debounced press advances that channel's brightness level through NUM_LEVELS steps and wraps to 0. Sits at top level between raw board buttons and the light/PWM drivers; a global all-off input clears every channel.

---
 rtl/light_ctrl_multi.sv | 171 +++++++++++++++++
 tb/tb_light_ctrl_multi.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/light_ctrl_multi.sv
`default_nettype none
// ============================================================================
//  Module      : light_ctrl_multi
//  Description : Multi-channel push-button light controller. Each channel has
//                a 2-flop synchroniser, a debouncer and a wrapping brightness
//                level counter that advances on every accepted press. A
//                global level-sensitive all-off input clears every level.
//                Optional macro LIGHT_LONG_PRESS_EN adds long-press detection
//                (level forced to 0) and defers short presses to release.
//  Revision    : 1.0 - initial release
// ============================================================================
module light_ctrl_multi #(
    parameter int NUM_CH          = 2,
    parameter int NUM_LEVELS      = 4,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int LONG_CYCLES     = 2000000,
    localparam int LVL_W          = ($clog2(NUM_LEVELS) > 1) ? $clog2(NUM_LEVELS) : 1
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic [NUM_CH-1:0]       i_button,
    input  logic                    i_all_off,
    output logic [NUM_CH*LVL_W-1:0] o_level,
    output logic [NUM_CH-1:0]       o_press,
    output logic [NUM_CH-1:0]       o_long
);

    // Debounce counter only has to reach DEBOUNCE_CYCLES-1 before the flip.
    localparam int DB_W = ($clog2(DEBOUNCE_CYCLES) > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    localparam logic [DB_W-1:0]  c_db_last = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LVL_W-1:0] c_lvl_max = LVL_W'(NUM_LEVELS - 1);

`ifdef LIGHT_LONG_PRESS_EN
    // Hold counter saturates at LONG_CYCLES so a single hold fires once.
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [HOLD_W-1:0] c_hold_full = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] c_hold_last = HOLD_W'(LONG_CYCLES - 1);
`else
    // LONG_CYCLES only matters when long-press support is compiled in.
    logic w_unused_long_cycles;
    assign w_unused_long_cycles = ^LONG_CYCLES;
`endif

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch

        logic             sync1_q, sync1_d;
        logic             sync2_q, sync2_d;
        logic             stable_q, stable_d;
        logic             stable_prev_q, stable_prev_d;
        logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
        logic [LVL_W-1:0] level_q, level_d;
        logic             press_q, press_d;
        logic             w_rise;
        logic [LVL_W-1:0] w_level_inc;

        // Wrap by compare so non-power-of-two level counts never overshoot.
        assign w_level_inc = (level_q == c_lvl_max) ? '0 : level_q + 1'b1;
        assign w_rise      = stable_q & ~stable_prev_q;

        // Synchroniser shift and debounce: stable flips after a full run of mismatches.
        always_comb begin
            sync1_d       = i_button[k];
            sync2_d       = sync1_q;
            stable_d      = stable_q;
            db_cnt_d      = '0;
            stable_prev_d = stable_q;
            if (sync2_q != stable_q) begin
                if (db_cnt_q == c_db_last) begin
                    stable_d = ~stable_q;
                    db_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
        end

`ifdef LIGHT_LONG_PRESS_EN
        logic [HOLD_W-1:0] hold_q, hold_d;
        logic              pending_q, pending_d;
        logic              long_q, long_d;
        logic              w_fall;
        logic              w_long_hit;

        assign w_fall     = ~stable_q & stable_prev_q;
        assign w_long_hit = stable_q & (hold_q == c_hold_last);

        // Level update: long hold clears, release advances if no long press fired.
        always_comb begin
            level_d   = level_q;
            press_d   = 1'b0;
            long_d    = 1'b0;
            hold_d    = hold_q;
            pending_d = pending_q;
            if (!stable_q) begin
                hold_d = '0;
            end else if (hold_q != c_hold_full) begin
                hold_d = hold_q + 1'b1;
            end
            if (w_rise) begin
                pending_d = 1'b1;
            end
            if (i_all_off) begin
                level_d   = '0;
                pending_d = 1'b0;
            end else if (w_long_hit) begin
                level_d   = '0;
                long_d    = 1'b1;
                pending_d = 1'b0;
            end else if (w_fall && pending_q) begin
                level_d   = w_level_inc;
                press_d   = 1'b1;
                pending_d = 1'b0;
            end
        end

        assign o_long[k] = long_q;
`else
        // Level update: advance on the debounced rising edge; all-off wins.
        always_comb begin
            level_d = level_q;
            press_d = 1'b0;
            if (i_all_off) begin
                level_d = '0;
            end else if (w_rise) begin
                level_d = w_level_inc;
                press_d = 1'b1;
            end
        end

        assign o_long[k] = 1'b0;
`endif

        // State registers for the whole channel, cleared asynchronously.
        always_ff @(posedge i_clk or posedge i_reset) begin
            if (i_reset) begin
                sync1_q       <= 1'b0;
                sync2_q       <= 1'b0;
                stable_q      <= 1'b0;
                stable_prev_q <= 1'b0;
                db_cnt_q      <= '0;
                level_q       <= '0;
                press_q       <= 1'b0;
`ifdef LIGHT_LONG_PRESS_EN
                hold_q        <= '0;
                pending_q     <= 1'b0;
                long_q        <= 1'b0;
`endif
            end else begin
                sync1_q       <= sync1_d;
                sync2_q       <= sync2_d;
                stable_q      <= stable_d;
                stable_prev_q <= stable_prev_d;
                db_cnt_q      <= db_cnt_d;
                level_q       <= level_d;
                press_q       <= press_d;
`ifdef LIGHT_LONG_PRESS_EN
                hold_q        <= hold_d;
                pending_q     <= pending_d;
                long_q        <= long_d;
`endif
            end
        end

        assign o_level[k*LVL_W +: LVL_W] = level_q;
        assign o_press[k]                = press_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_light_ctrl_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_light_ctrl_multi
//  Description : Randomised scoreboard bench for light_ctrl_multi (default
//                build, long-press feature not defined).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_light_ctrl_multi;

    localparam int NUM_CH     = 2;
    localparam int NUM_LEVELS = 3;
    localparam int DEB        = 4;
    localparam int LONG       = 20;
    localparam int LVL_W      = ($clog2(NUM_LEVELS) > 1) ? $clog2(NUM_LEVELS) : 1;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic [NUM_CH-1:0]       btn = '0;
    logic                    all_off = 1'b0;
    logic [NUM_CH*LVL_W-1:0] o_level;
    logic [NUM_CH-1:0]       o_press;
    logic [NUM_CH-1:0]       o_long;

    always #5 clk = ~clk;

    light_ctrl_multi #(
        .NUM_CH         (NUM_CH),
        .NUM_LEVELS     (NUM_LEVELS),
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONG)
    ) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .i_button (btn),
        .i_all_off(all_off),
        .o_level  (o_level),
        .o_press  (o_press),
        .o_long   (o_long)
    );

    typedef struct packed {
        int                      edge_no;
        logic [NUM_CH*LVL_W-1:0] level;
        logic [NUM_CH-1:0]       press;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   edge_no  = 0;

    // Reference model: per-channel behaviour stated in terms of input history.
    int          level_m [NUM_CH];
    bit          stable_m[NUM_CH];
    bit          rise_m  [NUM_CH];
    logic [63:0] bhist_m [NUM_CH];
    logic [63:0] shist_m [NUM_CH];
    int          since_m [NUM_CH];

    task automatic model_reset();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            level_m[ch]  = 0;
            stable_m[ch] = 1'b0;
            rise_m[ch]   = 1'b0;
            bhist_m[ch]  = '0;
            shist_m[ch]  = '0;
            since_m[ch]  = 0;
        end
        exp_q.delete();
    endtask

    // Predict what the next rising edge produces, queue it if it is visible.
    task automatic model_step(input logic [NUM_CH-1:0] b, input logic ao);
        exp_t e;
        bit   changed;
        int   old;
        bit   seen;
        bit   flip;
        changed   = 1'b0;
        e.edge_no = edge_no + 1;
        e.press   = '0;
        e.level   = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            old         = level_m[ch];
            bhist_m[ch] = {bhist_m[ch][62:0], b[ch]};
            seen        = bhist_m[ch][2];
            if (ao) begin
                level_m[ch] = 0;
            end else if (rise_m[ch]) begin
                level_m[ch] = (level_m[ch] + 1) % NUM_LEVELS;
                e.press[ch] = 1'b1;
            end
            if (level_m[ch] != old) changed = 1'b1;
            shist_m[ch] = {shist_m[ch][62:0], seen};
            since_m[ch] = since_m[ch] + 1;
            flip = (since_m[ch] >= DEB);
            for (int k = 0; k < DEB; k++) begin
                if (shist_m[ch][k] == stable_m[ch]) flip = 1'b0;
            end
            rise_m[ch] = flip && !stable_m[ch];
            if (flip) begin
                stable_m[ch] = !stable_m[ch];
                since_m[ch]  = 0;
            end
            e.level[ch*LVL_W +: LVL_W] = LVL_W'(level_m[ch]);
        end
        if (changed || (e.press != '0)) exp_q.push_back(e);
    endtask

    // Called at a falling edge; applies inputs for the next rising edge.
    task automatic drive(input logic [NUM_CH-1:0] b, input logic ao);
        btn     = b;
        all_off = ao;
        model_step(b, ao);
        @(negedge clk);
    endtask

    task automatic check_reset(input string name);
        checks++;
        if (o_level !== '0) begin
            failures++;
            $display("FAIL %s o_level: got %h expected 0", name, o_level);
        end
        checks++;
        if (o_press !== '0) begin
            failures++;
            $display("FAIL %s o_press: got %b expected 0", name, o_press);
        end
        checks++;
        if (o_long !== '0) begin
            failures++;
            $display("FAIL %s o_long: got %b expected 0", name, o_long);
        end
    endtask

    // Monitor: pops expected events and matches them against DUT output changes.
    logic [NUM_CH*LVL_W-1:0] last_level = '0;
    initial begin
        exp_t e;
        bit   dut_ev;
        forever begin
            @(posedge clk);
            edge_no++;
            #1;
            if (rst) begin
                last_level = '0;
            end else begin
                dut_ev = (o_press != '0) || (o_long != '0) || (o_level != last_level);
                while (exp_q.size() > 0 && exp_q[0].edge_no < edge_no) begin
                    e = exp_q.pop_front();
                    checks++;
                    failures++;
                    $display("FAIL missed_event edge %0d: expected level=%h press=%b never appeared",
                             e.edge_no, e.level, e.press);
                end
                if (exp_q.size() > 0 && exp_q[0].edge_no == edge_no) begin
                    e = exp_q.pop_front();
                    checks++;
                    if (o_level !== e.level || o_press !== e.press || o_long !== '0) begin
                        failures++;
                        $display("FAIL event edge %0d: got level=%h press=%b long=%b expected level=%h press=%b long=0",
                                 edge_no, o_level, o_press, o_long, e.level, e.press);
                    end
                end else if (dut_ev) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event edge %0d: got level=%h press=%b long=%b expected level=%h press=0 long=0",
                             edge_no, o_level, o_press, o_long, last_level);
                end
                last_level = o_level;
            end
        end
    end

    // Stimulus sequence.
    initial begin
        logic [NUM_CH-1:0] b;
        logic              v;
        int                len;
        int                cnt;

        #2 rst = 1'b1;
        model_reset();
        #1 check_reset("reset_initial");
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single clean press on channel 0.
        repeat (DEB + 4) drive(2'b01, 1'b0);
        repeat (DEB + 4) drive(2'b00, 1'b0);

        // Four clean presses on channel 1 exercise the wrap.
        for (int i = 0; i < 4; i++) begin
            repeat (DEB + 4) drive(2'b10, 1'b0);
            repeat (DEB + 4) drive(2'b00, 1'b0);
        end

        // Random clean presses, single and simultaneous.
        for (int i = 0; i < 10; i++) begin
            b   = NUM_CH'($urandom_range(1, 3));
            len = $urandom_range(DEB + 3, DEB + 8);
            repeat (len) drive(b, 1'b0);
            len = $urandom_range(DEB + 3, DEB + 8);
            repeat (len) drive(2'b00, 1'b0);
        end

        // Simultaneous press, then again with all-off on the update edge.
        repeat (DEB + 4) drive(2'b11, 1'b0);
        repeat (DEB + 4) drive(2'b00, 1'b0);
        for (int i = 0; i < DEB + 6; i++) drive(2'b11, logic'(rise_m[0] & rise_m[1]));
        repeat (DEB + 4) drive(2'b00, 1'b0);

        // Bounce on channel 0 with 1..3 cycle pulses, then a steady hold.
        v   = 1'b0;
        cnt = 0;
        while (cnt < 50) begin
            v   = ~v;
            len = $urandom_range(1, 3);
            repeat (len) drive({1'b0, v}, 1'b0);
            cnt = cnt + len;
        end
        repeat (DEB + 6) drive(2'b01, 1'b0);
        repeat (DEB + 6) drive(2'b00, 1'b0);

        // Glitch one cycle shorter than the debounce window.
        repeat (DEB - 1) drive(2'b01, 1'b0);
        repeat (DEB + 6) drive(2'b00, 1'b0);

        // Reset mid-press with both buttons held, then release.
        repeat (DEB + 5) drive(2'b11, 1'b0);
        #2 rst = 1'b1;
        model_reset();
        #1 check_reset("reset_async");
        repeat (3) @(negedge clk);
        check_reset("reset_held");
        rst = 1'b0;
        repeat (DEB + 6) drive(2'b11, 1'b0);
        repeat (DEB + 6) drive(2'b00, 1'b0);

        // Random buttons with occasional all-off.
        for (int i = 0; i < 60; i++) begin
            b   = NUM_CH'($urandom_range(0, 3));
            len = $urandom_range(1, 12);
            for (int j = 0; j < len; j++) drive(b, ($urandom_range(0, 15) == 0));
        end

        repeat (DEB + 12) drive(2'b00, 1'b0);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected events, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
